// File: rtl/data_mem_io.sv
// Data-memory responder: word RAM/stack, TX byte FIFO, status register and cycle counter.
// Latency: loads are combinational; stores, pushes and pops take effect at the rising edge.
// Backpressure: tx_data holds while tx_valid && !tx_ready; a push into a full FIFO with no pop is dropped and sets ovf.
module data_mem_io #(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] IO_BASE    = 16'h7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_Addr,
    input  logic [15:0] write_data,
    input  logic        write_enable,
    output logic [15:0] read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_CYCLE  = 4'h2;

    typedef struct packed {
        logic [7:0] rsvd;
        logic [3:0] count;
        logic       zero;
        logic       ovf;
        logic       full;
        logic       empty;
    } status_t;

    logic              io_sel;
    logic [3:0]        offset;
    logic [ADDR_W-1:0] ram_idx;

    logic [15:0]      ram_q [2**ADDR_W];
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      cyc_q, cyc_d;

    logic    push, pop, accept, drop, full, empty;
    logic    status_wr, cyc_wr;
    logic [3:0] cnt_sat;
    status_t status;

    assign io_sel  = (data_Addr[15:4] == IO_BASE[15:4]);
    assign offset  = data_Addr[3:0];
    assign ram_idx = data_Addr[ADDR_W-1:0];

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign push      = write_enable && io_sel && (offset == OFF_TXDATA);
    assign pop       = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign status_wr = write_enable && io_sel && (offset == OFF_STATUS);
    assign cyc_wr    = write_enable && io_sel && (offset == OFF_CYCLE);

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (status_wr && write_data[2]) ovf_d = 1'b0;
        if (drop)                       ovf_d = 1'b1;
    end

    assign cyc_d = cyc_wr ? write_data : cyc_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
        end
    end

    // Storage arrays are not reset; tx_data is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (write_enable && !io_sel) ram_q[ram_idx] <= write_data;
    end

    always_comb begin
        cnt_sat = (int'(count_q) > 15) ? 4'hF : 4'(count_q);
        status  = '{rsvd: 8'h00, count: cnt_sat, zero: 1'b0, ovf: ovf_q, full: full, empty: empty};
    end

    always_comb begin
        read_data = 16'h0000;
        if (io_sel) begin
            case (offset)
                OFF_STATUS: read_data = status;
                OFF_CYCLE:  read_data = cyc_q;
                default:    read_data = 16'h0000;
            endcase
        end else begin
            read_data = ram_q[ram_idx];
        end
    end

endmodule
